seg7_display_scanner: RTL and testbench

- Display-side consumer of the 16-bit up/down counter value.
- Takes a 16-bit word, shows it as 4 hex digits on the board's multiplexed common-anode 7-segment display.
- Contains a refresh prescaler, a digit-scan counter, a per-frame snapshot register (no tearing mid-frame) and registered segment/anode outputs.
- Sits between the counter's OUT bus and the top-level display pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_display_scanner_hex_to_seg7.sv | 12 +
 rtl/seg7_display_scanner.sv | 127 ++++++++++++
 tb/tb_seg7_display_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display scanner.
// Holds the active-low hex segment table, blank/off constants and the digit index type.
package seg7_pkg;

    // Digit position 0..3, 0 = rightmost digit.
    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] DIGIT_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_display_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
// Ports: nibble_in (4-bit hex digit), seg_out (7-bit {g,f,e,d,c,b,a}, active-low).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_in,
    output logic [6:0] seg_out
);

    assign seg_out = SEG_TABLE[nibble_in];

endmodule

// File: rtl/seg7_display_scanner.sv
// Multiplexed 4-digit common-anode hex display scanner with per-frame snapshot.
// Ports: CLK, RESET (async high), VALUE_IN[15:0], DP_IN[3:0] in;
// SEG_OUT[6:0], DP_OUT, DIGIT_SEL_OUT[3:0] out (all active-low).
module seg7_display_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b0
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] VALUE_IN,
    input  logic [3:0]  DP_IN,
    output logic [6:0]  SEG_OUT,
    output logic        DP_OUT,
    output logic [3:0]  DIGIT_SEL_OUT
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   snap_val_q, snap_val_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic          upd_q, upd_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    sel_q, sel_d;

    logic          strobe;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    dec_seg;

    hex_to_seg7 u_dec (
        .nibble_in (nibble),
        .seg_out   (dec_seg)
    );

    assign strobe = (pre_q == PRE_LAST);

    // Prescaler, scan index and frame snapshot.
    always_comb begin
        pre_d      = pre_q + PW'(1);
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        // Outputs follow one cycle behind the index change.
        upd_d      = strobe;
        if (strobe) begin
            pre_d = '0;
            idx_d = idx_q + digit_idx_t'(1);
            // Capture only at frame start so a frame never mixes two values.
            if (idx_q == digit_idx_t'(3)) begin
                snap_val_d = VALUE_IN;
                snap_dp_d  = DP_IN;
            end
        end
    end

    // Nibble select and leading-zero blanking for the current digit.
    always_comb begin
        nibble = snap_val_q[3:0];
        blank  = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nibble = snap_val_q[3:0];
            end
            2'd1: begin
                nibble = snap_val_q[7:4];
                blank  = (snap_val_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = snap_val_q[11:8];
                blank  = (snap_val_q[15:8] == 8'h00);
            end
            2'd3: begin
                nibble = snap_val_q[15:12];
                blank  = (snap_val_q[15:12] == 4'h0);
            end
        endcase
        if (!BLANK_LEADING) begin
            blank = 1'b0;
        end
    end

    // Registered outputs, held between updates.
    always_comb begin
        seg_d = seg_q;
        dp_d  = dp_q;
        sel_d = sel_q;
        if (upd_q) begin
            seg_d = blank ? SEG_BLANK : dec_seg;
            dp_d  = ~snap_dp_q[idx_q];
            sel_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_q      <= '0;
            idx_q      <= digit_idx_t'(3);
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            upd_q      <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            sel_q      <= DIGIT_OFF;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            upd_q      <= upd_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            sel_q      <= sel_d;
        end
    end

    assign SEG_OUT       = seg_q;
    assign DP_OUT        = dp_q;
    assign DIGIT_SEL_OUT = sel_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Self-checking bench for seg7_display_scanner (REFRESH_DIV=4).
// Two instances (no blanking / leading-zero blanking) share one stimulus.
module tb_seg7_display_scanner;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] VALUE_IN;
    logic [3:0]  DP_IN;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  sel_a, sel_b;

    int checks = 0;
    int errors = 0;

    seg7_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .VALUE_IN      (VALUE_IN),
        .DP_IN         (DP_IN),
        .SEG_OUT       (seg_a),
        .DP_OUT        (dp_a),
        .DIGIT_SEL_OUT (sel_a)
    );

    seg7_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut_b (
        .CLK           (CLK),
        .RESET         (RESET),
        .VALUE_IN      (VALUE_IN),
        .DP_IN         (DP_IN),
        .SEG_OUT       (seg_b),
        .DP_OUT        (dp_b),
        .DIGIT_SEL_OUT (sel_b)
    );

    always #5 CLK = ~CLK;

    // Hex glyphs straight from the display's character table.
    logic [6:0] glyph [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: edge n after reset release; strobe every 4th edge,
    // frame starts on strobes 1,5,9..; outputs show up one edge later.
    int          n;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [6:0]  e_seg_a, e_seg_b;
    logic        e_dp;
    logic [3:0]  e_sel;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            n       = 0;
            m_val   = 16'h0;
            m_dp    = 4'h0;
            e_seg_a = 7'h7F;
            e_seg_b = 7'h7F;
            e_dp    = 1'b1;
            e_sel   = 4'hF;
        end else begin
            n = n + 1;
            if (n % 4 == 0 && ((n / 4) - 1) % 4 == 0) begin
                m_val = VALUE_IN;
                m_dp  = DP_IN;
            end
            if (n >= 5 && n % 4 == 1) begin
                int d;
                d       = (((n - 1) / 4) - 1) % 4;
                e_seg_a = glyph[(m_val >> (4 * d)) & 16'hF];
                if (d > 0 && (m_val >> (4 * d)) == 0)
                    e_seg_b = 7'h7F;
                else
                    e_seg_b = e_seg_a;
                e_dp  = ~m_dp[d];
                e_sel = 4'hF ^ (4'(1) << d);
            end
        end
    end

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".seg"},   seg_a,        e_seg_a);
        chk({tag, ".dp"},    7'(dp_a),     7'(e_dp));
        chk({tag, ".sel"},   7'(sel_a),    7'(e_sel));
        chk({tag, ".segB"},  seg_b,        e_seg_b);
        chk({tag, ".dpB"},   7'(dp_b),     7'(e_dp));
        chk({tag, ".selB"},  7'(sel_b),    7'(e_sel));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        @(negedge CLK);
        chk_model(tag);
    endtask

    task automatic run_to(input int target, input string tag);
        while (n < target) step(tag);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".seg"}, seg_a,     7'h7F);
        chk({tag, ".dp"},  7'(dp_a),  7'h01);
        chk({tag, ".sel"}, 7'(sel_a), 7'h0F);
        chk({tag, ".segB"}, seg_b,    7'h7F);
    endtask

    initial begin
        RESET    = 1'b1;
        VALUE_IN = 16'h0;
        DP_IN    = 4'h0;
        repeat (3) begin
            @(negedge CLK);
            chk_dark("rst_hold");
        end
        VALUE_IN = 16'h1234;
        RESET    = 1'b0;

        // Scan order
        run_to(4, "pre");
        chk_dark("pre_first");
        run_to(5, "scan");
        chk("c5.sel", 7'(sel_a), 7'h0E);
        chk("c5.seg", seg_a, 7'h19);
        run_to(9, "scan");
        chk("c9.sel", 7'(sel_a), 7'h0D);
        chk("c9.seg", seg_a, 7'h30);
        run_to(13, "scan");
        chk("c13.sel", 7'(sel_a), 7'h0B);
        chk("c13.seg", seg_a, 7'h24);
        run_to(17, "scan");
        chk("c17.sel", 7'(sel_a), 7'h07);
        chk("c17.seg", seg_a, 7'h79);
        run_to(21, "scan");
        chk("c21.sel", 7'(sel_a), 7'h0E);
        chk("c21.seg", seg_a, 7'h19);

        // Snapshot holds through a mid-frame change
        VALUE_IN = 16'hABCD;
        run_to(41, "snap");
        chk("snap.d1", seg_a, 7'h46);
        VALUE_IN = 16'h0000;
        run_to(45, "snap");
        chk("snap.d2", seg_a, 7'h03);
        run_to(49, "snap");
        chk("snap.d3", seg_a, 7'h08);
        run_to(53, "snap");
        chk("snap.next", seg_a, 7'h40);

        // Leading-zero blanking
        VALUE_IN = 16'h0050;
        run_to(69, "blank");
        chk("blk.d0", seg_b, 7'h40);
        run_to(73, "blank");
        chk("blk.d1", seg_b, 7'h12);
        run_to(77, "blank");
        chk("blk.d2", seg_b, 7'h7F);
        chk("blk.d2sel", 7'(sel_b), 7'h0B);
        VALUE_IN = 16'h0000;
        run_to(85, "blank0");
        chk("blk0.d0", seg_b, 7'h40);
        run_to(89, "blank0");
        chk("blk0.d1", seg_b, 7'h7F);

        // Decimal point
        VALUE_IN = 16'hFFFF;
        DP_IN    = 4'b0100;
        run_to(105, "dp");
        chk("dp.d1", 7'(dp_a), 7'h01);
        run_to(109, "dp");
        chk("dp.d2", 7'(dp_a), 7'h00);
        chk("dp.d2sel", 7'(sel_a), 7'h0B);
        chk("dp.d2seg", seg_a, 7'h0E);

        // Async reset between edges while digit 2 is lit
        #1 RESET = 1'b1;
        #1 chk_dark("async");
        #1 RESET = 1'b0;
        run_to(4, "post_rst");
        chk_dark("post_rst4");
        run_to(5, "post_rst");
        chk("post_rst5.sel", 7'(sel_a), 7'h0E);
        chk("post_rst5.seg", seg_a, 7'h0E);

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            step("rand");
            if ($urandom_range(0, 9) < 3)
                VALUE_IN = 16'($urandom) >> $urandom_range(0, 16);
            if ($urandom_range(0, 9) < 2)
                DP_IN = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 RESET = 1'b1;
                #1 chk_model("rand_rst");
                #1 RESET = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
